// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control unit:
// opcodes, ALU flag codes, PC source codes, FSM states, op classes.
package multicycle_control_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_WB_AL  = 4'd3,
    S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5,
    S_MEM    = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    C_ALU  = 3'd0,
    C_BR   = 3'd1,
    C_LS   = 3'd2,
    C_J    = 3'd3,
    C_HALT = 3'd4,
    C_ILL  = 3'd5
  } op_class_e;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode decode: op -> ALU flag, ALUSrcB, RegDst,
// ExtSel and op class. Ports: op in; decoded controls out.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] alu_flag,
  output logic       alu_src_b,
  output logic       reg_dst,
  output logic       ext_sel,
  output op_class_e  op_class
);

  always_comb begin
    alu_flag  = ALU_ADD;
    alu_src_b = 1'b0;
    reg_dst   = 1'b0;
    ext_sel   = 1'b1;
    op_class  = C_ILL;
    case (op)
      OP_ADD: begin
        op_class = C_ALU;
        reg_dst  = 1'b1;
      end
      OP_SUB: begin
        op_class = C_ALU;
        alu_flag = ALU_SUB;
        reg_dst  = 1'b1;
      end
      OP_ADDI: begin
        op_class  = C_ALU;
        alu_src_b = 1'b1;
      end
      OP_OR: begin
        op_class = C_ALU;
        alu_flag = ALU_OR;
        reg_dst  = 1'b1;
      end
      OP_AND: begin
        op_class = C_ALU;
        alu_flag = ALU_AND;
        reg_dst  = 1'b1;
      end
      OP_ORI: begin
        op_class  = C_ALU;
        alu_flag  = ALU_OR;
        alu_src_b = 1'b1;
        ext_sel   = 1'b0;
      end
      OP_SW, OP_LW: op_class = C_LS;
      OP_BEQ: begin
        op_class = C_BR;
        alu_flag = ALU_SUB;
      end
      OP_J:    op_class = C_J;
      OP_HALT: op_class = C_HALT;
      default: op_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM: sequences IF/ID/EXE/MEM/WB,
// drives datapath strobes, counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             InsMemRW,
  output logic             IRWre,
  output logic             ExtSel,
  output logic             ALUSrcB,
  output logic [2:0]       ALUFlag,
  output logic             RegWre,
  output logic             RegDst,
  output logic             mRD,
  output logic             mWR,
  output logic             DBDataSrc,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] dec_op;
  logic [2:0] dec_flag;
  logic       dec_src_b;
  logic       dec_reg_dst;
  logic       dec_ext;
  op_class_e  dec_class;

  // ID decodes the live IR; later phases use the latched op
  assign dec_op = (state_q == S_ID) ? opcode : op_q;

  multicycle_control_decode u_dec (
    .op        (dec_op),
    .alu_flag  (dec_flag),
    .alu_src_b (dec_src_b),
    .reg_dst   (dec_reg_dst),
    .ext_sel   (dec_ext),
    .op_class  (dec_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_q_d     = op_q;
    PCWre      = 1'b0;
    PCSrc      = PC_NEXT;
    InsMemRW   = 1'b0;
    IRWre      = 1'b0;
    ExtSel     = 1'b0;
    ALUSrcB    = 1'b0;
    ALUFlag    = ALU_ADD;
    RegWre     = 1'b0;
    RegDst     = 1'b0;
    mRD        = 1'b0;
    mWR        = 1'b0;
    DBDataSrc  = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        ExtSel = dec_ext;
        op_q_d = opcode;
        unique case (dec_class)
          C_ALU:  state_d = S_EXE_AL;
          C_BR:   state_d = S_EXE_BR;
          C_LS:   state_d = S_EXE_LS;
          C_HALT: state_d = S_HALT;
          C_J: begin
            PCWre   = 1'b1;
            PCSrc   = PC_JMP;
            state_d = S_IF;
          end
          default: begin
            PCWre      = 1'b1;
            illegal_op = 1'b1;
            state_d    = S_IF;
          end
        endcase
      end
      S_EXE_AL: begin
        ExtSel  = dec_ext;
        ALUSrcB = dec_src_b;
        ALUFlag = dec_flag;
        state_d = S_WB_AL;
      end
      S_WB_AL: begin
        ExtSel  = dec_ext;
        ALUSrcB = dec_src_b;
        ALUFlag = dec_flag;
        RegWre  = 1'b1;
        RegDst  = dec_reg_dst;
        PCWre   = 1'b1;
        state_d = S_IF;
      end
      S_EXE_BR: begin
        ExtSel  = dec_ext;
        ALUFlag = ALU_SUB;
        PCWre   = 1'b1;
        // branch target chosen from this cycle's compare result
        PCSrc   = zero ? PC_BR : PC_NEXT;
        state_d = S_IF;
      end
      S_EXE_LS: begin
        ExtSel  = dec_ext;
        ALUSrcB = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        ExtSel  = dec_ext;
        ALUSrcB = 1'b1;
        if (op_q == OP_SW) begin
          mWR     = 1'b1;
          PCWre   = 1'b1;
          state_d = S_IF;
        end else begin
          mRD     = 1'b1;
          state_d = S_WB_LD;
        end
      end
      S_WB_LD: begin
        ExtSel    = dec_ext;
        ALUSrcB   = 1'b1;
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: begin
        ExtSel = dec_ext;
        halted = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    cnt_d = PCWre ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
